null_src_burst_ctrl: RTL and testbench

// - Sequences the null source datapath: turns start/stop commands into framed
//   AXI-Stream payload packets carrying the null-source line pattern.
// - Applies a configurable inter-packet gap, honours an optional packet limit,
//   and flags EOB on the final packet of every burst.
// - Sits between the register file (config/command) and the CHDR framer of the

---
 rtl/null_src_burst_ctrl_if.sv | 27 ++
 rtl/null_src_burst_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_null_src_burst_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/null_src_burst_ctrl_if.sv
// AXI-Stream style payload bus between the null-source burst controller and the CHDR framer.
// The master drives the line, framing flags and valid; the slave returns ready.
interface null_src_burst_ctrl_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_eob;

    modport master (
        output m_tdata,
        output m_tlast,
        output m_tvalid,
        output m_eob,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tlast,
        input  m_tvalid,
        input  m_eob,
        output m_tready
    );
endinterface

// File: rtl/null_src_burst_ctrl.sv
// Null-source burst controller: turns start/stop commands into framed packets of the
// line-index pattern, with an optional inter-packet gap and packet limit, and EOB on the last packet.
module null_src_burst_ctrl #(
    parameter int ITEM_W = 32,
    parameter int NIPC   = 2,
    parameter int LPP_W  = 16,
    parameter int GAP_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                 rfnoc_chdr_clk,
    input  logic                 rfnoc_chdr_rst,
    input  logic [LPP_W-1:0]     cfg_lines_per_pkt,
    input  logic [GAP_W-1:0]     cfg_gap_cycles,
    input  logic [CNT_W-1:0]     cfg_num_pkts,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic                 clear_cnt,
    null_src_burst_ctrl_if.master m,
    output logic                 busy,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     line_cnt
);

    localparam int DATA_W = ITEM_W * NIPC;
    localparam int HALF_W = ITEM_W / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LPP_W-1:0]    lpp_q, lpp_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    burst_q, burst_d;
    logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
    logic                stopPend_q, stopPend_d;
    logic [CNT_W-1:0]    lineIdx_q, lineIdx_d;
    logic [LPP_W-1:0]    linePos_q, linePos_d;
    logic                tvalid_q, tvalid_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tlast_q, tlast_d;
    logic                eob_q, eob_d;
    logic [CNT_W-1:0]    pktCnt_q, pktCnt_d;
    logic [CNT_W-1:0]    lineCnt_q, lineCnt_d;

    logic                handshake;
    logic                loadBeat;
    logic [LPP_W-1:0]    loadPos;
    logic [CNT_W-1:0]    loadIdx;
    logic [LPP_W-1:0]    lppEff;
    logic [CNT_W-1:0]    numEff;
    logic [CNT_W-1:0]    burstEff;
    logic                stopEff;
    logic [HALF_W-1:0]   half;
    logic [ITEM_W-1:0]   item;

    assign handshake  = tvalid_q & m.m_tready;
    assign m.m_tdata  = tdata_q;
    assign m.m_tlast  = tlast_q;
    assign m.m_tvalid = tvalid_q;
    assign m.m_eob    = eob_q;
    assign busy       = (state_q != IDLE);
    assign pkt_cnt    = pktCnt_q;
    assign line_cnt   = lineCnt_q;

    // The *Eff values describe the beat being loaded this cycle, so a start can use cfg directly
    always_comb begin
        state_d    = state_q;
        lpp_d      = lpp_q;
        gap_d      = gap_q;
        num_d      = num_q;
        burst_d    = burst_q;
        gapCnt_d   = gapCnt_q;
        stopPend_d = stopPend_q;
        lineIdx_d  = lineIdx_q;
        linePos_d  = linePos_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        eob_d      = eob_q;
        loadBeat   = 1'b0;
        loadPos    = '0;
        loadIdx    = lineIdx_q;
        lppEff     = lpp_q;
        numEff     = num_q;
        burstEff   = burst_q;
        stopEff    = stopPend_q | cmd_stop;
        half       = '0;
        item       = '0;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    lpp_d      = cfg_lines_per_pkt;
                    gap_d      = cfg_gap_cycles;
                    num_d      = cfg_num_pkts;
                    burst_d    = '0;
                    stopPend_d = cmd_stop;
                    state_d    = DATA;
                    loadBeat   = 1'b1;
                    loadIdx    = '0;
                    lppEff     = cfg_lines_per_pkt;
                    numEff     = cfg_num_pkts;
                    burstEff   = '0;
                    stopEff    = cmd_stop;
                end
            end
            DATA: begin
                if (cmd_stop) begin
                    stopPend_d = 1'b1;
                end
                if (handshake) begin
                    if (tlast_q) begin
                        if (eob_q) begin
                            state_d    = IDLE;
                            tvalid_d   = 1'b0;
                            tlast_d    = 1'b0;
                            eob_d      = 1'b0;
                            stopPend_d = 1'b0;
                        end else begin
                            burst_d  = burst_q + CNT_W'(1);
                            burstEff = burst_q + CNT_W'(1);
                            if (gap_q == '0) begin
                                loadBeat = 1'b1;
                            end else begin
                                state_d  = GAP;
                                gapCnt_d = '0;
                                tvalid_d = 1'b0;
                                tlast_d  = 1'b0;
                                eob_d    = 1'b0;
                            end
                        end
                    end else begin
                        loadBeat = 1'b1;
                        loadPos  = linePos_q + LPP_W'(1);
                    end
                end
            end
            GAP: begin
                if (cmd_stop) begin
                    stopPend_d = 1'b1;
                end
                if (gapCnt_q == gap_q - GAP_W'(1)) begin
                    state_d  = DATA;
                    loadBeat = 1'b1;
                end else begin
                    gapCnt_d = gapCnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // EOB is decided when the tlast beat is loaded so it never changes while stalled
        if (loadBeat) begin
            half      = loadIdx[HALF_W-1:0];
            item      = {~half, half};
            tvalid_d  = 1'b1;
            tdata_d   = {NIPC{item}};
            lineIdx_d = loadIdx + CNT_W'(1);
            linePos_d = loadPos;
            tlast_d   = (loadPos == lppEff);
            eob_d     = (loadPos == lppEff) &&
                        (stopEff || ((numEff != '0) && (burstEff + CNT_W'(1) == numEff)));
        end
    end

    always_comb begin
        pktCnt_d  = pktCnt_q;
        lineCnt_d = lineCnt_q;
        if (clear_cnt) begin
            pktCnt_d  = '0;
            lineCnt_d = '0;
        end else if (handshake) begin
            lineCnt_d = lineCnt_q + CNT_W'(1);
            if (tlast_q) begin
                pktCnt_d = pktCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge rfnoc_chdr_clk) begin
        if (rfnoc_chdr_rst) begin
            state_q    <= IDLE;
            lpp_q      <= '0;
            gap_q      <= '0;
            num_q      <= '0;
            burst_q    <= '0;
            gapCnt_q   <= '0;
            stopPend_q <= 1'b0;
            lineIdx_q  <= '0;
            linePos_q  <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            eob_q      <= 1'b0;
            pktCnt_q   <= '0;
            lineCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lpp_q      <= lpp_d;
            gap_q      <= gap_d;
            num_q      <= num_d;
            burst_q    <= burst_d;
            gapCnt_q   <= gapCnt_d;
            stopPend_q <= stopPend_d;
            lineIdx_q  <= lineIdx_d;
            linePos_q  <= linePos_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            eob_q      <= eob_d;
            pktCnt_q   <= pktCnt_d;
            lineCnt_q  <= lineCnt_d;
        end
    end

endmodule

// File: tb/tb_null_src_burst_ctrl.sv
// Self-checking bench for null_src_burst_ctrl: expected beats are queued when a burst is
// started and compared as the DUT hands them off, alongside hold, gap and counter checks.
module tb_null_src_burst_ctrl;

    localparam int ITEM_W = 32;
    localparam int NIPC   = 2;
    localparam int LPP_W  = 16;
    localparam int GAP_W  = 16;
    localparam int CNT_W  = 32;
    localparam int DATA_W = ITEM_W * NIPC;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              eob;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [LPP_W-1:0]  cfgLpp = '0;
    logic [GAP_W-1:0]  cfgGap = '0;
    logic [CNT_W-1:0]  cfgNum = '0;
    logic              cmdStart = 1'b0;
    logic              cmdStop = 1'b0;
    logic              clearCnt = 1'b0;
    logic              tready = 1'b1;
    logic              busy;
    logic [CNT_W-1:0]  pktCnt;
    logic [CNT_W-1:0]  lineCnt;

    beat_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    int    expGap = 0;
    bit    randomReady = 1'b0;

    null_src_burst_ctrl_if #(.DATA_W(DATA_W)) busIf ();
    assign busIf.m_tready = tready;

    null_src_burst_ctrl #(
        .ITEM_W(ITEM_W), .NIPC(NIPC), .LPP_W(LPP_W), .GAP_W(GAP_W), .CNT_W(CNT_W)
    ) dut (
        .rfnoc_chdr_clk   (clk),
        .rfnoc_chdr_rst   (rst),
        .cfg_lines_per_pkt(cfgLpp),
        .cfg_gap_cycles   (cfgGap),
        .cfg_num_pkts     (cfgNum),
        .cmd_start        (cmdStart),
        .cmd_stop         (cmdStop),
        .clear_cnt        (clearCnt),
        .m                (busIf.master),
        .busy             (busy),
        .pkt_cnt          (pktCnt),
        .line_cnt         (lineCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] pattern(input int unsigned i);
        logic [15:0] h;
        h = i[15:0];
        return {~h, h, ~h, h};
    endfunction

    task automatic pushBurst(input int lpp, input int nPkts);
        int idx = 0;
        for (int p = 0; p < nPkts; p++) begin
            for (int l = 0; l <= lpp; l++) begin
                expQ.push_back('{data: pattern(idx), last: (l == lpp), eob: (l == lpp) && (p == nPkts - 1)});
                idx++;
            end
        end
    endtask

    task automatic applyStimulus(input int lpp, input int gap, input int num, input bit withStop, input int nPkts);
        @(posedge clk); #1;
        cfgLpp   = LPP_W'(lpp);
        cfgGap   = GAP_W'(gap);
        cfgNum   = CNT_W'(num);
        cmdStart = 1'b1;
        cmdStop  = withStop;
        expGap   = gap;
        pushBurst(lpp, nPkts);
        @(posedge clk); #1;
        cmdStart = 1'b0;
        cmdStop  = 1'b0;
    endtask

    task automatic clearCounters();
        @(posedge clk); #1;
        clearCnt = 1'b1;
        @(posedge clk); #1;
        clearCnt = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while ((busy || expQ.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(n >= budget), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic waitBeat(input string tag, input logic [DATA_W-1:0] data, input bit needLast, input int budget);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (busIf.m_tvalid && busIf.m_tdata == data && (!needLast || (busIf.m_tlast && tready)))
                found = 1'b1;
        end
        checkOutput(tag, 64'(found), 64'd1);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        tready = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    beat_t held;
    beat_t expBeat;
    bit    stalled = 1'b0;
    bit    measuring = 1'b0;
    int    gapRun = 0;

    always @(negedge clk) begin
        if (rst) begin
            stalled   = 1'b0;
            measuring = 1'b0;
        end else begin
            if (stalled) begin
                checkOutput("hold tvalid", 64'(busIf.m_tvalid), 64'd1);
                checkOutput("hold tdata", busIf.m_tdata, held.data);
                checkOutput("hold last/eob", 64'({busIf.m_tlast, busIf.m_eob}), 64'({held.last, held.eob}));
            end
            if (measuring) begin
                if (!busIf.m_tvalid) begin
                    gapRun++;
                end else begin
                    checkOutput("gap length", 64'(gapRun), 64'(expGap));
                    measuring = 1'b0;
                end
            end
            if (busIf.m_tvalid && tready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected beat", 64'd1, 64'd0);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("beat tdata", busIf.m_tdata, expBeat.data);
                    checkOutput("beat tlast", 64'(busIf.m_tlast), 64'(expBeat.last));
                    checkOutput("beat eob", 64'(busIf.m_eob), 64'(expBeat.eob));
                end
                if (busIf.m_tlast && !busIf.m_eob) begin
                    measuring = 1'b1;
                    gapRun    = 0;
                end
                stalled = 1'b0;
            end else if (busIf.m_tvalid) begin
                stalled = 1'b1;
                held    = '{data: busIf.m_tdata, last: busIf.m_tlast, eob: busIf.m_eob};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tvalid", 64'(busIf.m_tvalid), 64'd0);
        checkOutput("reset tlast/eob", 64'({busIf.m_tlast, busIf.m_eob}), 64'd0);
        checkOutput("reset tdata", busIf.m_tdata, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset counters", {pktCnt, lineCnt}, 64'd0);
        rst = 1'b0;

        $display("[TB] T1 limited burst with ignored start while busy");
        applyStimulus(3, 0, 5, 1'b0, 5);
        repeat (2) @(posedge clk);
        #1;
        cfgLpp   = LPP_W'(0);
        cfgNum   = CNT_W'(1);
        cmdStart = 1'b1;
        @(posedge clk); #1;
        cmdStart = 1'b0;
        waitDone("T1 done", 200);
        checkOutput("T1 pkt_cnt", 64'(pktCnt), 64'd5);
        checkOutput("T1 line_cnt", 64'(lineCnt), 64'd20);
        checkOutput("T1 busy", 64'(busy), 64'd0);

        $display("[TB] T2 stop mid-packet");
        clearCounters();
        applyStimulus(9, 0, 0, 1'b0, 2);
        waitBeat("T2 line 13 seen", pattern(13), 1'b0, 100);
        cmdStop = 1'b1;
        @(posedge clk); #1;
        cmdStop = 1'b0;
        waitDone("T2 done", 200);
        checkOutput("T2 line_cnt", 64'(lineCnt), 64'd20);
        checkOutput("T2 pkt_cnt", 64'(pktCnt), 64'd2);

        $display("[TB] T3 gap");
        clearCounters();
        applyStimulus(1, 3, 3, 1'b0, 3);
        waitDone("T3 done", 200);
        checkOutput("T3 line_cnt", 64'(lineCnt), 64'd6);
        checkOutput("T3 pkt_cnt", 64'(pktCnt), 64'd3);

        $display("[TB] T4 backpressure");
        clearCounters();
        randomReady = 1'b1;
        applyStimulus(3, 0, 5, 1'b0, 5);
        waitDone("T4 done", 1000);
        randomReady = 1'b0;
        checkOutput("T4 pkt_cnt", 64'(pktCnt), 64'd5);
        checkOutput("T4 line_cnt", 64'(lineCnt), 64'd20);

        $display("[TB] T5 corner commands");
        clearCounters();
        applyStimulus(2, 0, 0, 1'b1, 1);
        waitDone("T5 start+stop done", 100);
        checkOutput("T5 start+stop pkt_cnt", 64'(pktCnt), 64'd1);
        @(posedge clk); #1;
        cmdStop = 1'b1;
        @(posedge clk); #1;
        cmdStop = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("T5 idle stop busy", 64'(busy), 64'd0);
        checkOutput("T5 idle stop tvalid", 64'(busIf.m_tvalid), 64'd0);
        applyStimulus(3, 0, 1, 1'b0, 1);
        waitBeat("T5 tlast seen", pattern(3), 1'b1, 100);
        clearCnt = 1'b1;
        @(posedge clk); #1;
        clearCnt = 1'b0;
        checkOutput("T5 clear on tlast pkt_cnt", 64'(pktCnt), 64'd0);
        checkOutput("T5 clear on tlast line_cnt", 64'(lineCnt), 64'd0);
        waitDone("T5 clear burst done", 100);

        $display("[TB] T6 reset mid-burst");
        applyStimulus(7, 0, 0, 1'b0, 0);
        for (int k = 0; k < 3; k++)
            expQ.push_back('{data: pattern(k), last: 1'b0, eob: 1'b0});
        waitBeat("T6 line 2 seen", pattern(2), 1'b0, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("T6 tvalid after reset", 64'(busIf.m_tvalid), 64'd0);
        checkOutput("T6 tlast/eob after reset", 64'({busIf.m_tlast, busIf.m_eob}), 64'd0);
        checkOutput("T6 counters after reset", {pktCnt, lineCnt}, 64'd0);
        checkOutput("T6 busy after reset", 64'(busy), 64'd0);
        checkOutput("T6 queue drained", 64'(expQ.size()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1, 0, 1, 1'b0, 1);
        waitDone("T6 restart done", 100);
        checkOutput("T6 restart line_cnt", 64'(lineCnt), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
